// File: rtl/lcdc_host_pkg.sv
// Shared definitions for the LCD controller host command interface.
// Holds opcodes, FSM encoding and parameter counts used by decoder and bench.
package lcdc_host_pkg;

    localparam logic [7:0] CMD_SYSSET   = 8'h40;
    localparam logic [7:0] CMD_MWRITE   = 8'h42;
    localparam logic [7:0] CMD_SCROLL   = 8'h44;
    localparam logic [7:0] CMD_CSRW     = 8'h46;
    localparam logic [7:0] CMD_DISP_OFF = 8'h58;
    localparam logic [7:0] CMD_DISP_ON  = 8'h59;

    localparam logic [7:0] SYSSET_NPAR = 8'd8;
    localparam logic [7:0] SCROLL_NPAR = 8'd10;
    localparam logic [7:0] CSRW_NPAR   = 8'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYSSET,
        ST_SCROLL,
        ST_CSRW,
        ST_DISP,
        ST_MWRITE,
        ST_IGNORE
    } state_t;

    function automatic state_t cmd_to_state(input logic [7:0] op);
        case (op)
            CMD_SYSSET:   return ST_SYSSET;
            CMD_SCROLL:   return ST_SCROLL;
            CMD_CSRW:     return ST_CSRW;
            CMD_DISP_OFF: return ST_DISP;
            CMD_DISP_ON:  return ST_DISP;
            CMD_MWRITE:   return ST_MWRITE;
            default:      return ST_IGNORE;
        endcase
    endfunction

endpackage

// File: rtl/host_cmd_ctrl_if.sv
// Asynchronous host write bus: chip enable, address, write strobe, data.
// Host drives it (master); the controller only samples it (slave).
interface host_cmd_ctrl_if;
  logic       ce_x;
  logic       a0;
  logic       wr_x;
  logic [7:0] dat;

  modport master (output ce_x, a0, wr_x, dat);
  modport slave  (input  ce_x, a0, wr_x, dat);
endinterface

// File: rtl/host_wr_sync.sv
// Synchronizes the host bus into clk and emits one strobe per wr_x rising edge.
// Strobe appears SYNC_STAGES clk after the edge; no backpressure, host is never stalled.
module host_wr_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce_x,
  input  logic       a0,
  input  logic       wr_x,
  input  logic [7:0] dat,
  output logic       stb,
  output logic       stb_a0,
  output logic [7:0] stb_dat
);

  logic [SYNC_STAGES-1:0] ce_s;
  logic [SYNC_STAGES-1:0] wr_s;
  logic [SYNC_STAGES-1:0] a0_s;
  logic [7:0]             dat_s [SYNC_STAGES];
  logic                   wr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      ce_s    <= '1;
      wr_s    <= '1;
      a0_s    <= '0;
      wr_d    <= 1'b1;
      stb_a0  <= 1'b0;
      stb_dat <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) dat_s[i] <= '0;
    end else begin
      ce_s[0]  <= ce_x;
      wr_s[0]  <= wr_x;
      a0_s[0]  <= a0;
      dat_s[0] <= dat;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        ce_s[i]  <= ce_s[i-1];
        wr_s[i]  <= wr_s[i-1];
        a0_s[i]  <= a0_s[i-1];
        dat_s[i] <= dat_s[i-1];
      end
      // a0/dat taken one sample behind, i.e. while wr_x was still low
      wr_d    <= wr_s[SYNC_STAGES-1];
      stb_a0  <= a0_s[SYNC_STAGES-1];
      stb_dat <= dat_s[SYNC_STAGES-1];
    end
  end

  assign stb = wr_s[SYNC_STAGES-1] & ~wr_d & ~ce_s[SYNC_STAGES-1];

endmodule

// File: rtl/host_cmd_ctrl.sv
// Host command decoder: SYSTEM SET, SCROLL, CSRW, DISP ON/OFF and MWRITE into config registers.
// Update SYNC_STAGES+1 clk after wr_x rises; no backpressure, every host write is consumed.
module host_cmd_ctrl
  import lcdc_host_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] MAX_PAR     = 8'd255
) (
  input  logic                   clk,
  input  logic                   rst,
  host_cmd_ctrl_if.slave         host,
  output logic [7:0]             reg_cr,
  output logic [7:0]             reg_tcr,
  output logic [7:0]             reg_lf,
  output logic [15:0]            reg_ap,
  output logic [15:0]            reg_sad1,
  output logic [15:0]            reg_csr,
  output logic                   disp_en,
  output logic                   cfg_upd,
  output logic                   mem_wr,
  output logic [15:0]            mem_addr,
  output logic [7:0]             mem_dat
);

  logic       stb;
  logic       stb_a0;
  logic [7:0] stb_dat;
  state_t     state;
  logic [7:0] par_idx;

  host_wr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .ce_x    (host.ce_x),
    .a0      (host.a0),
    .wr_x    (host.wr_x),
    .dat     (host.dat),
    .stb     (stb),
    .stb_a0  (stb_a0),
    .stb_dat (stb_dat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      par_idx  <= '0;
      reg_cr   <= '0;
      reg_tcr  <= '0;
      reg_lf   <= '0;
      reg_ap   <= '0;
      reg_sad1 <= '0;
      reg_csr  <= '0;
      disp_en  <= 1'b0;
      cfg_upd  <= 1'b0;
      mem_wr   <= 1'b0;
      mem_addr <= '0;
      mem_dat  <= '0;
    end else begin
      cfg_upd <= 1'b0;
      mem_wr  <= 1'b0;
      if (stb && stb_a0) begin
        // a new command always wins; partially written registers stay as they are
        state   <= cmd_to_state(stb_dat);
        par_idx <= '0;
        if (stb_dat == CMD_DISP_OFF || stb_dat == CMD_DISP_ON) disp_en <= stb_dat[0];
      end else if (stb) begin
        if (par_idx != MAX_PAR) par_idx <= par_idx + 8'd1;
        if (par_idx == MAX_PAR && state != ST_MWRITE) begin
          state <= ST_IGNORE;
        end else begin
          case (state)
            ST_SYSSET: begin
              case (par_idx)
                8'd3:    reg_cr        <= stb_dat;
                8'd4:    reg_tcr       <= stb_dat;
                8'd5:    reg_lf        <= stb_dat;
                8'd6:    reg_ap[7:0]   <= stb_dat;
                8'd7:    reg_ap[15:8]  <= stb_dat;
                default: ;
              endcase
              if (par_idx == SYSSET_NPAR - 8'd1) begin
                cfg_upd <= 1'b1;
                state   <= ST_IDLE;
              end
            end
            ST_SCROLL: begin
              if (par_idx == 8'd0) reg_sad1[7:0]  <= stb_dat;
              if (par_idx == 8'd1) reg_sad1[15:8] <= stb_dat;
              if (par_idx == SCROLL_NPAR - 8'd1) state <= ST_IDLE;
            end
            ST_CSRW: begin
              if (par_idx == 8'd0) reg_csr[7:0] <= stb_dat;
              if (par_idx == CSRW_NPAR - 8'd1) begin
                reg_csr[15:8] <= stb_dat;
                state         <= ST_IDLE;
              end
            end
            ST_DISP: state <= ST_IDLE;
            ST_MWRITE: begin
              mem_wr   <= 1'b1;
              mem_addr <= reg_csr;
              mem_dat  <= stb_dat;
              reg_csr  <= reg_csr + 16'd1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_host_cmd_ctrl.sv
// Directed host-bus sequences; expected mem_wr/cfg_upd pulses go into a queue checked by a monitor.
module tb_host_cmd_ctrl;
  import lcdc_host_pkg::*;

  localparam int SYNC_STAGES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  reg_cr, reg_tcr, reg_lf;
  logic [15:0] reg_ap, reg_sad1, reg_csr;
  logic        disp_en, cfg_upd, mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_dat;

  host_cmd_ctrl_if hbus ();

  host_cmd_ctrl #(.SYNC_STAGES(SYNC_STAGES), .MAX_PAR(8'd255)) dut (
    .clk      (clk),
    .rst      (rst),
    .host     (hbus.slave),
    .reg_cr   (reg_cr),
    .reg_tcr  (reg_tcr),
    .reg_lf   (reg_lf),
    .reg_ap   (reg_ap),
    .reg_sad1 (reg_sad1),
    .reg_csr  (reg_csr),
    .disp_en  (disp_en),
    .cfg_upd  (cfg_upd),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_dat  (mem_dat)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_cfg;
    logic [15:0] addr;
    logic [7:0]  d;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle with a pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mem_wr || cfg_upd) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got mem_wr=%0b cfg_upd=%0b addr=%h dat=%h required no pulse",
                 cyc, mem_wr, cfg_upd, mem_addr, mem_dat);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_cfg ? !(cfg_upd && !mem_wr && cyc == mon_e.cyc)
                         : !(mem_wr && !cfg_upd && mem_addr == mon_e.addr &&
                             mem_dat == mon_e.d && cyc == mon_e.cyc)) begin
          errors++;
          $display("FAIL pulse got cfg=%0b mem=%0b addr=%h dat=%h cyc=%0d required cfg=%0b addr=%h dat=%h cyc=%0d",
                   cfg_upd, mem_wr, mem_addr, mem_dat, cyc,
                   mon_e.is_cfg, mon_e.addr, mon_e.d, mon_e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input logic [7:0] cr, input logic [7:0] tcr, input logic [7:0] lf,
                          input logic [15:0] ap, input logic [15:0] sad1, input logic [15:0] csr,
                          input logic de);
    chk("reg_cr",   {8'h00, reg_cr},  {8'h00, cr});
    chk("reg_tcr",  {8'h00, reg_tcr}, {8'h00, tcr});
    chk("reg_lf",   {8'h00, reg_lf},  {8'h00, lf});
    chk("reg_ap",   reg_ap,   ap);
    chk("reg_sad1", reg_sad1, sad1);
    chk("reg_csr",  reg_csr,  csr);
    chk("disp_en",  {15'h0, disp_en}, {15'h0, de});
  endtask

  // kind: 0 no pulse expected, 1 mem_wr at ea, 2 cfg_upd
  task automatic host_wr(input bit a0v, input logic [7:0] d, input bit ce_on,
                         input int kind, input logic [15:0] ea);
    ev_t e;
    @(negedge clk);
    hbus.ce_x = ~ce_on; hbus.a0 = a0v; hbus.dat = d; hbus.wr_x = 1'b1;
    @(negedge clk);
    hbus.wr_x = 1'b0;
    repeat (2) @(negedge clk);
    hbus.wr_x = 1'b1;
    if (kind != 0) begin
      e.is_cfg = (kind == 2);
      e.addr   = ea;
      e.d      = d;
      e.cyc    = cyc + SYNC_STAGES + 1;
      exp_q.push_back(e);
    end
    repeat (2) @(negedge clk);
    hbus.ce_x = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] d);                      host_wr(1'b1, d, 1'b1, 0, 16'h0); endtask
  task automatic par(input logic [7:0] d);                      host_wr(1'b0, d, 1'b1, 0, 16'h0); endtask
  task automatic mem(input logic [7:0] d, input logic [15:0] a); host_wr(1'b0, d, 1'b1, 1, a);     endtask

  logic [7:0] sys_par [8];

  initial begin
    hbus.ce_x = 1'b1; hbus.wr_x = 1'b1; hbus.a0 = 1'b0; hbus.dat = 8'h00;
    sys_par = '{8'h30, 8'h87, 8'h07, 8'h27, 8'h39, 8'hEF, 8'h28, 8'h00};
    repeat (3) @(negedge clk);
    chk_regs(8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    chk("rst_mem_wr", {15'h0, mem_wr}, 16'h0);
    chk("rst_cfg_upd", {15'h0, cfg_upd}, 16'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // SYSTEM SET: last parameter completes and pulses cfg_upd
    cmd(CMD_SYSSET);
    for (int i = 0; i < 7; i++) par(sys_par[i]);
    host_wr(1'b0, sys_par[7], 1'b1, 2, 16'h0);
    chk_regs(8'h27, 8'h39, 8'hEF, 16'h0028, 16'h0000, 16'h0000, 1'b0);

    // SCROLL: two live bytes, eight discarded, then back to IDLE
    cmd(CMD_SCROLL);
    par(8'h00); par(8'h12);
    for (int i = 1; i <= 8; i++) par(8'(i));
    par(8'hEE);
    chk("scroll_sad1", reg_sad1, 16'h1200);

    // CSRW then MWRITE two bytes
    cmd(CMD_CSRW); par(8'h00); par(8'h10);
    chk("csrw_csr", reg_csr, 16'h1000);
    cmd(CMD_MWRITE);
    mem(8'h55, 16'h1000);
    mem(8'h48, 16'h1001);
    chk("mwrite_csr", reg_csr, 16'h1002);

    // cursor wrap
    cmd(CMD_CSRW); par(8'hFF); par(8'hFF);
    cmd(CMD_MWRITE);
    mem(8'hA5, 16'hFFFF);
    chk("wrap_csr", reg_csr, 16'h0000);

    // SYSTEM SET aborted by DISP ON; following params discarded
    cmd(CMD_SYSSET); par(8'h11); par(8'h22); par(8'h33);
    cmd(CMD_DISP_ON);
    par(8'h44); par(8'h55);
    chk_regs(8'h27, 8'h39, 8'hEF, 16'h0028, 16'h1200, 16'h0000, 1'b1);
    cmd(CMD_DISP_OFF);
    chk("disp_off", {15'h0, disp_en}, 16'h0);

    // unknown opcode and writes with ce_x high
    cmd(8'h99); par(8'hAA); par(8'hBB);
    chk_regs(8'h27, 8'h39, 8'hEF, 16'h0028, 16'h1200, 16'h0000, 1'b0);
    cmd(CMD_MWRITE);
    host_wr(1'b0, 8'h12, 1'b0, 0, 16'h0);
    host_wr(1'b0, 8'h34, 1'b0, 0, 16'h0);
    host_wr(1'b1, CMD_SYSSET, 1'b0, 0, 16'h0);
    mem(8'h9C, 16'h0000);
    chk("ce_high_csr", reg_csr, 16'h0001);

    // reset in the middle of an MWRITE byte
    cmd(CMD_DISP_ON); par(8'h00);
    cmd(CMD_CSRW); par(8'h12); par(8'h34);
    cmd(CMD_MWRITE);
    mem(8'h5A, 16'h3412);
    chk("pre_rst_csr", reg_csr, 16'h3413);
    chk("pre_rst_mem_dat", {8'h00, mem_dat}, 16'h005A);
    @(negedge clk);
    hbus.ce_x = 1'b0; hbus.a0 = 1'b0; hbus.dat = 8'h77; hbus.wr_x = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); hbus.wr_x = 1'b1;
    @(negedge clk);
    chk_regs(8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_dat", {8'h00, mem_dat}, 16'h0000);
    hbus.ce_x = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    par(8'h3C);
    chk("post_rst_csr", reg_csr, 16'h0000);
    chk("post_rst_mem_addr", mem_addr, 16'h0000);

    repeat (10) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses got %0d outstanding required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
